// File: rtl/tetromino_bag_queue.sv
// 7-bag tetromino randomizer feeding a small lookahead FIFO; one pop per req cycle.
// Optional head+1 preview output is built only when TETRIS_BAG_PREVIEW_EN is defined.
module tetromino_bag_queue #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED   = 16'h0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic [2:0] piece,
    output logic       piece_valid,
    output logic [2:0] bag_left,
    output logic [3:0] fill_level,
    output logic       underflow,
    output logic [2:0] preview,
    output logic       preview_valid
);

    // An all-zero Galois LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // Handshake: req is a pop request honoured only while piece_valid=1; the
    // head advances at that edge and the new head appears on piece after it.
    logic [15:0] lfsr_q, lfsr_d;
    logic [6:0]  mask_q, mask_d, mask_clr;
    logic [2:0]  mem_q [0:7];
    logic [2:0]  rd_q, rd_d, wr_q, wr_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  piece_q, piece_d, head_d;
    logic        valid_q, uf_q;
    logic [2:0]  start, draw, idx;
    logic [3:0]  sum;
    logic        pop, push;

    function automatic logic [2:0] nxt(input logic [2:0] p);
        return (p == 3'(QUEUE_DEPTH - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // Scan from start upward (wrapping 6->0); descending k lets the nearest hit win.
    always_comb begin
        start = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
        draw  = 3'd0;
        sum   = 4'd0;
        idx   = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            sum = {1'b0, start} + 4'(k);
            idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
            if (mask_q[idx]) draw = idx;
        end
    end

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        pop      = req && valid_q;
        push     = (count_q != 4'(QUEUE_DEPTH)) || pop;
        mask_clr = mask_q & ~(7'b1 << draw);
        mask_d   = mask_q;
        if (push) mask_d = (mask_clr == 7'h00) ? 7'h7F : mask_clr;
        rd_d     = pop ? nxt(rd_q) : rd_q;
        wr_d     = push ? nxt(wr_q) : wr_q;
        count_d  = count_q + {3'b000, push} - {3'b000, pop};
        // The pushed piece bypasses the array when it lands on the new head slot.
        head_d   = (push && (wr_q == rd_d)) ? draw : mem_q[rd_d];
        piece_d  = (count_d != 4'd0) ? head_d : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= SEED;
            mask_q  <= 7'h7F;
            rd_q    <= 3'd0;
            wr_q    <= 3'd0;
            count_q <= 4'd0;
            piece_q <= 3'd0;
            valid_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            piece_q <= piece_d;
            valid_q <= (count_d != 4'd0);
            uf_q    <= uf_q | (req & ~valid_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_q] <= draw;
    end

    assign piece       = piece_q;
    assign piece_valid = valid_q;
    assign bag_left    = 3'($countones(mask_q));
    assign fill_level  = count_q;
    assign underflow   = uf_q;

`ifdef TETRIS_BAG_PREVIEW_EN
    logic [2:0] pv_idx, pv_d, preview_q;
    logic       preview_valid_q;

    always_comb begin
        pv_idx = nxt(rd_d);
        pv_d   = 3'd0;
        if (count_d >= 4'd2) pv_d = (push && (wr_q == pv_idx)) ? draw : mem_q[pv_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            preview_q       <= 3'd0;
            preview_valid_q <= 1'b0;
        end else begin
            preview_q       <= pv_d;
            preview_valid_q <= (count_d >= 4'd2);
        end
    end

    assign preview       = preview_q;
    assign preview_valid = preview_valid_q;
`else
    assign preview       = 3'd0;
    assign preview_valid = 1'b0;
`endif

endmodule

// File: tb/tb_tetromino_bag_queue.sv
// Directed bench for tetromino_bag_queue: default, zero-seed and depth-2 instances.
module tb_tetromino_bag_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic rst2 = 1'b1;
  logic req2 = 1'b0;

  logic [2:0] piece, bag_left, preview;
  logic       piece_valid, underflow, preview_valid;
  logic [3:0] fill_level;

  logic [2:0] s0_piece, s0_bag_left, s0_preview;
  logic       s0_piece_valid, s0_underflow, s0_preview_valid;
  logic [3:0] s0_fill_level;

  logic [2:0] d2_piece, d2_bag_left, d2_preview;
  logic       d2_piece_valid, d2_underflow, d2_preview_valid;
  logic [3:0] d2_fill_level;

  int tot = 0;
  int bad = 0;

  // reference model of the default instance (depth 4, seed 1)
  logic [15:0] m_lfsr;
  logic [6:0]  m_mask;
  logic        m_uf;
  logic [2:0]  exp_q[$];

  logic [2:0] first4 [4];

  always #5 clk = ~clk;

  tetromino_bag_queue #(.QUEUE_DEPTH(4), .LFSR_SEED(16'h0001)) dut (
    .clk(clk), .rst(rst), .req(req), .piece(piece), .piece_valid(piece_valid),
    .bag_left(bag_left), .fill_level(fill_level), .underflow(underflow),
    .preview(preview), .preview_valid(preview_valid)
  );

  tetromino_bag_queue #(.QUEUE_DEPTH(4), .LFSR_SEED(16'h0000)) dut_s0 (
    .clk(clk), .rst(rst), .req(req), .piece(s0_piece), .piece_valid(s0_piece_valid),
    .bag_left(s0_bag_left), .fill_level(s0_fill_level), .underflow(s0_underflow),
    .preview(s0_preview), .preview_valid(s0_preview_valid)
  );

  tetromino_bag_queue #(.QUEUE_DEPTH(2), .LFSR_SEED(16'h0001)) dut_d2 (
    .clk(clk), .rst(rst2), .req(req2), .piece(d2_piece), .piece_valid(d2_piece_valid),
    .bag_left(d2_bag_left), .fill_level(d2_fill_level), .underflow(d2_underflow),
    .preview(d2_preview), .preview_valid(d2_preview_valid)
  );

  // drive one cycle of rst/req, advance the model by the same edge, sample 1ns after
  task automatic step(input logic r, input logic q);
    int start, p, i;
    logic do_pop, do_push, found;
    rst = r;
    req = q;
    if (r) begin
      m_lfsr = 16'h0001;
      m_mask = 7'h7F;
      m_uf   = 1'b0;
      exp_q.delete();
    end else begin
      do_pop = q && (exp_q.size() != 0);
      if (q && exp_q.size() == 0) m_uf = 1'b1;
      do_push = (exp_q.size() < 4) || do_pop;
      start = int'(m_lfsr[2:0]);
      if (start == 7) start = 0;
      p = 0;
      found = 1'b0;
      for (int k = 0; k < 7; k++) begin
        i = (start + k) % 7;
        if (!found && m_mask[i]) begin
          p = i;
          found = 1'b1;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(3'(p));
        m_mask[p] = 1'b0;
        if (m_mask == 7'h00) m_mask = 7'h7F;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    tot++; if (fill_level !== 4'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill_level); end
    tot++; if (piece !== 3'd0) begin bad++; $display("FAIL reset_piece got=%0d want=0", piece); end
    tot++; if (piece_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d want=0", piece_valid); end
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_uf got=%0d want=0", underflow); end
    tot++; if (bag_left !== 3'd7) begin bad++; $display("FAIL reset_bag got=%0d want=7", bag_left); end
    tot++; if (preview !== 3'd0) begin bad++; $display("FAIL reset_preview got=%0d want=0", preview); end
    tot++; if (preview_valid !== 1'b0) begin bad++; $display("FAIL reset_pvalid got=%0d want=0", preview_valid); end
    tot++; if (s0_bag_left !== 3'd7) begin bad++; $display("FAIL reset_s0_bag got=%0d want=7", s0_bag_left); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      tot++; if (fill_level !== 4'(i + 1)) begin bad++; $display("FAIL fill_level[%0d] got=%0d want=%0d", i, fill_level, i + 1); end
      tot++; if (piece_valid !== 1'b1) begin bad++; $display("FAIL fill_valid[%0d] got=%0d want=1", i, piece_valid); end
      tot++; if (piece !== 3'd1) begin bad++; $display("FAIL fill_head[%0d] got=%0d want=1", i, piece); end
      tot++; if (s0_piece !== 3'd1) begin bad++; $display("FAIL seed0_head[%0d] got=%0d want=1", i, s0_piece); end
    end
    tot++; if (bag_left !== 3'd3) begin bad++; $display("FAIL fill_bag got=%0d want=3", bag_left); end
`ifdef TETRIS_BAG_PREVIEW_EN
    tot++; if (preview !== 3'd0) begin bad++; $display("FAIL fill_preview got=%0d want=0", preview); end
    tot++; if (preview_valid !== 1'b1) begin bad++; $display("FAIL fill_pvalid got=%0d want=1", preview_valid); end
`else
    tot++; if (preview_valid !== 1'b0) begin bad++; $display("FAIL fill_pvalid got=%0d want=0", preview_valid); end
`endif
    step(1'b0, 1'b0);
    tot++; if (fill_level !== 4'd4) begin bad++; $display("FAIL full_hold got=%0d want=4", fill_level); end
    tot++; if (bag_left !== 3'd3) begin bad++; $display("FAIL full_bag got=%0d want=3", bag_left); end
  endtask

  task automatic test_bag();
    logic [2:0] log_q [14];
    logic [6:0] seen0, seen1;
    for (int i = 0; i < 14; i++) begin
      log_q[i] = piece;
      tot++; if (piece !== exp_q[0]) begin bad++; $display("FAIL bag_head[%0d] got=%0d want=%0d", i, piece, exp_q[0]); end
      tot++; if (s0_piece !== exp_q[0]) begin bad++; $display("FAIL bag_s0_head[%0d] got=%0d want=%0d", i, s0_piece, exp_q[0]); end
      if (i < 4) begin
        tot++; if (piece !== first4[i]) begin bad++; $display("FAIL bag_order[%0d] got=%0d want=%0d", i, piece, first4[i]); end
      end
      step(1'b0, 1'b1);
      tot++; if (bag_left !== 3'($countones(m_mask))) begin bad++; $display("FAIL bag_left[%0d] got=%0d want=%0d", i, bag_left, $countones(m_mask)); end
      if (i == 2 || i == 9) begin
        tot++; if (bag_left !== 3'd7) begin bad++; $display("FAIL bag_reload[%0d] got=%0d want=7", i, bag_left); end
      end
      tot++; if (fill_level !== 4'd4) begin bad++; $display("FAIL bag_fill[%0d] got=%0d want=4", i, fill_level); end
      step(1'b0, 1'b0);
    end
    seen0 = 7'h00;
    seen1 = 7'h00;
    for (int i = 0; i < 7; i++) begin
      if (log_q[i] < 3'd7) seen0[log_q[i]] = 1'b1;
      if (log_q[i + 7] < 3'd7) seen1[log_q[i + 7]] = 1'b1;
    end
    tot++; if (seen0 !== 7'h7F) begin bad++; $display("FAIL bag_perm0 got=%h want=7f", seen0); end
    tot++; if (seen1 !== 7'h7F) begin bad++; $display("FAIL bag_perm1 got=%h want=7f", seen1); end
  endtask

  task automatic test_full_pop();
    logic [2:0] pv;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      tot++; if (fill_level !== 4'd4) begin bad++; $display("FAIL fp_fill[%0d] got=%0d want=4", i, fill_level); end
      tot++; if (piece_valid !== 1'b1) begin bad++; $display("FAIL fp_valid[%0d] got=%0d want=1", i, piece_valid); end
      tot++; if (piece !== exp_q[0]) begin bad++; $display("FAIL fp_head[%0d] got=%0d want=%0d", i, piece, exp_q[0]); end
`ifdef TETRIS_BAG_PREVIEW_EN
      pv = exp_q[1];
`else
      pv = 3'd0;
`endif
      tot++; if (preview !== pv) begin bad++; $display("FAIL fp_preview[%0d] got=%0d want=%0d", i, preview, pv); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    tot++; if (fill_level !== 4'd0) begin bad++; $display("FAIL mid_fill got=%0d want=0", fill_level); end
    tot++; if (piece !== 3'd0) begin bad++; $display("FAIL mid_piece got=%0d want=0", piece); end
    tot++; if (piece_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0d want=0", piece_valid); end
    tot++; if (bag_left !== 3'd7) begin bad++; $display("FAIL mid_bag got=%0d want=7", bag_left); end
    tot++; if (preview_valid !== 1'b0) begin bad++; $display("FAIL mid_pvalid got=%0d want=0", preview_valid); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      tot++; if (fill_level !== 4'(i + 1)) begin bad++; $display("FAIL mid_refill[%0d] got=%0d want=%0d", i, fill_level, i + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      tot++; if (piece !== first4[i]) begin bad++; $display("FAIL mid_order[%0d] got=%0d want=%0d", i, piece, first4[i]); end
      step(1'b0, 1'b1);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_in_rst got=%0d want=0", underflow); end
    tot++; if (fill_level !== 4'd0) begin bad++; $display("FAIL uf_rst_fill got=%0d want=0", fill_level); end
    step(1'b0, 1'b0);
    tot++; if (fill_level !== 4'd1) begin bad++; $display("FAIL uf_first_fill got=%0d want=1", fill_level); end
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_first got=%0d want=0", underflow); end
    step(1'b0, 1'b1);
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_valid_pop got=%0d want=0", underflow); end
    tot++; if (fill_level !== 4'(exp_q.size())) begin bad++; $display("FAIL uf_pop_fill got=%0d want=%0d", fill_level, exp_q.size()); end

    // depth-2 instance; the default instance idles in reset meanwhile
    rst2 = 1'b1; req2 = 1'b0;
    step(1'b1, 1'b0);
    rst2 = 1'b1; req2 = 1'b1;
    step(1'b1, 1'b0);
    tot++; if (d2_underflow !== 1'b0) begin bad++; $display("FAIL d2_rst_req got=%0d want=0", d2_underflow); end
    tot++; if (d2_fill_level !== 4'd0) begin bad++; $display("FAIL d2_rst_fill got=%0d want=0", d2_fill_level); end
    rst2 = 1'b0; req2 = 1'b1;
    step(1'b1, 1'b0);
    tot++; if (d2_underflow !== 1'b1) begin bad++; $display("FAIL d2_uf_set got=%0d want=1", d2_underflow); end
    tot++; if (d2_fill_level !== 4'd1) begin bad++; $display("FAIL d2_fill1 got=%0d want=1", d2_fill_level); end
    tot++; if (d2_piece !== 3'd1) begin bad++; $display("FAIL d2_head got=%0d want=1", d2_piece); end
    req2 = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    tot++; if (d2_fill_level !== 4'd2) begin bad++; $display("FAIL d2_full got=%0d want=2", d2_fill_level); end
    tot++; if (d2_underflow !== 1'b1) begin bad++; $display("FAIL d2_uf_hold got=%0d want=1", d2_underflow); end
`ifdef TETRIS_BAG_PREVIEW_EN
    tot++; if (d2_preview !== 3'd0 || d2_preview_valid !== 1'b1) begin bad++; $display("FAIL d2_preview got=%0d/%0d want=0/1", d2_preview, d2_preview_valid); end
`endif
    req2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      tot++; if (d2_fill_level !== 4'd2 || d2_piece_valid !== 1'b1) begin bad++; $display("FAIL d2_pop[%0d] got=%0d/%0d want=2/1", i, d2_fill_level, d2_piece_valid); end
      tot++; if (d2_underflow !== 1'b1) begin bad++; $display("FAIL d2_uf_sticky[%0d] got=%0d want=1", i, d2_underflow); end
    end
    rst2 = 1'b1; req2 = 1'b0;
    step(1'b1, 1'b0);
    tot++; if (d2_underflow !== 1'b0) begin bad++; $display("FAIL d2_uf_clear got=%0d want=0", d2_underflow); end
    tot++; if (d2_bag_left !== 3'd7 || d2_fill_level !== 4'd0) begin bad++; $display("FAIL d2_reset got=%0d/%0d want=7/0", d2_bag_left, d2_fill_level); end
  endtask

  initial begin
    first4[0] = 3'd1; first4[1] = 3'd0; first4[2] = 3'd2; first4[3] = 3'd3;
    test_reset();
    test_fill();
    test_bag();
    test_full_pop();
    test_reset_mid();
    test_underflow();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
